onewire_master_ctrl: RTL and testbench

- Synthesizable 1-wire bus master controller; clocked RTL counterpart of the behavioural 1-wire master model used on the bench.
- Accepts one command at a time: bus reset/presence detect, write byte, or read byte.
- Sequences bus timing with a microsecond prescaler and a slot counter; drives the open-drain line through an output-enable.
- Sits between a host register interface or CPU and the external pulled-up 1-wire pin.

---
 rtl/onewire_master_ctrl_if.sv | 30 +++
 rtl/onewire_master_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_onewire_master_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onewire_master_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : onewire_master_ctrl_if
// Brief    : Host command/response handshake plus the 1-wire pad pins.
// Revision : 1.0
// ============================================================================
interface onewire_master_ctrl_if;
  logic       cmd_vld;
  logic       cmd_rdy;
  logic [1:0] cmd_op;
  logic [7:0] cmd_dat;
  logic       rsp_vld;
  logic [7:0] rsp_dat;
  logic       rsp_pre;
  logic       rsp_err;
  logic       owr_oe;
  logic       owr_i;

  // master = host issuing commands (and the pad model), slave = controller
  modport master (
    output cmd_vld, cmd_op, cmd_dat, owr_i,
    input  cmd_rdy, rsp_vld, rsp_dat, rsp_pre, rsp_err, owr_oe
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_dat, owr_i,
    output cmd_rdy, rsp_vld, rsp_dat, rsp_pre, rsp_err, owr_oe
  );
endinterface
`default_nettype wire

// File: rtl/onewire_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : onewire_master_ctrl
// Brief    : 1-wire bus master: reset/presence, write byte, read byte.
// Revision : 1.0
// ============================================================================
module onewire_master_ctrl #(
  parameter int CDR   = 10,
  parameter int TRSTL = 480,
  parameter int TRSTH = 480,
  parameter int TPDS  = 70,
  parameter int TLOW0 = 60,
  parameter int TLOW1 = 6,
  parameter int TRDS  = 15,
  parameter int TSLOT = 70
) (
  input  wire logic             clk,
  input  wire logic             rst,
  onewire_master_ctrl_if.slave  bus
);

  localparam int c_us_a   = (TRSTL > TRSTH) ? TRSTL : TRSTH;
  localparam int c_us_max = (c_us_a > TSLOT) ? c_us_a : TSLOT;
  localparam int c_us_w   = $clog2(c_us_max + 1);
  localparam int c_pre_w  = $clog2(CDR);

  localparam logic [c_pre_w-1:0] c_cdr_m1   = c_pre_w'(CDR - 1);
  localparam logic [c_us_w-1:0]  c_trstl_m1 = c_us_w'(TRSTL - 1);
  localparam logic [c_us_w-1:0]  c_trsth_m1 = c_us_w'(TRSTH - 1);
  localparam logic [c_us_w-1:0]  c_tpds_m1  = c_us_w'(TPDS - 1);
  localparam logic [c_us_w-1:0]  c_tlow0_m1 = c_us_w'(TLOW0 - 1);
  localparam logic [c_us_w-1:0]  c_tlow1_m1 = c_us_w'(TLOW1 - 1);
  localparam logic [c_us_w-1:0]  c_trds_m1  = c_us_w'(TRDS - 1);
  localparam logic [c_us_w-1:0]  c_tslot_m1 = c_us_w'(TSLOT - 1);

  localparam logic [1:0] c_op_rst = 2'b00;
  localparam logic [1:0] c_op_wr  = 2'b01;
  localparam logic [1:0] c_op_rd  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_LOW  = 3'd1,
    S_RST_HIGH = 3'd2,
    S_BIT_LOW  = 3'd3,
    S_BIT_HIGH = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t               r_state;
  logic [c_pre_w-1:0]   r_presc;
  logic [c_us_w-1:0]    r_us;
  logic [2:0]           r_bit;
  logic [1:0]           r_op;
  logic [7:0]           r_wdat;
  logic [7:0]           r_shift;
  logic [1:0]           r_sync;
  logic                 r_pre_smp;
  logic                 r_err_smp;
  logic                 r_oe;
  logic                 r_rsp_vld;
  logic [7:0]           r_rsp_dat;
  logic                 r_rsp_pre;
  logic                 r_rsp_err;

  logic                 w_tick;
  logic                 w_rd_smp;
  logic [c_us_w-1:0]    w_tlow_m1;

  assign w_tick    = (r_presc == c_cdr_m1);
  assign w_rd_smp  = w_tick && (r_us == c_trds_m1);
  assign w_tlow_m1 = r_wdat[r_bit] ? c_tlow1_m1 : c_tlow0_m1;

  assign bus.cmd_rdy = (r_state == S_IDLE) && !rst;
  assign bus.rsp_vld = r_rsp_vld;
  assign bus.rsp_dat = r_rsp_dat;
  assign bus.rsp_pre = r_rsp_pre;
  assign bus.rsp_err = r_rsp_err;
  assign bus.owr_oe  = r_oe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_us      <= '0;
      r_bit     <= '0;
      r_op      <= '0;
      r_wdat    <= '0;
      r_shift   <= '0;
      r_sync    <= 2'b11;
      r_pre_smp <= 1'b0;
      r_err_smp <= 1'b0;
      r_oe      <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= '0;
      r_rsp_pre <= 1'b0;
      r_rsp_err <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], bus.owr_i};
      r_rsp_vld <= 1'b0;

      // Prescaler is held at zero while idle so each phase starts phase-aligned
      if (r_state == S_IDLE || w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.cmd_vld) begin
            r_op      <= bus.cmd_op;
            r_us      <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_pre_smp <= 1'b0;
            r_err_smp <= 1'b0;
            case (bus.cmd_op)
              c_op_rst: begin
                r_oe    <= 1'b1;
                r_state <= S_RST_LOW;
              end
              c_op_wr: begin
                r_wdat  <= bus.cmd_dat;
                r_oe    <= 1'b1;
                r_state <= S_BIT_LOW;
              end
              c_op_rd: begin
                r_wdat  <= 8'hFF;
                r_oe    <= 1'b1;
                r_state <= S_BIT_LOW;
              end
              default: r_state <= S_DONE;
            endcase
          end
        end

        S_RST_LOW: begin
          if (w_tick) begin
            if (r_us == c_trstl_m1) begin
              r_us    <= '0;
              r_oe    <= 1'b0;
              r_state <= S_RST_HIGH;
            end else begin
              r_us <= r_us + 1'b1;
            end
          end
        end

        S_RST_HIGH: begin
          if (w_tick) begin
            if (r_us == c_tpds_m1) begin
              r_pre_smp <= ~r_sync[1];
            end
            if (r_us == c_trsth_m1) begin
              r_err_smp <= ~r_sync[1];
              r_us      <= '0;
              r_state   <= S_DONE;
            end else begin
              r_us <= r_us + 1'b1;
            end
          end
        end

        // r_us runs across the whole slot; the low phase just ends earlier
        S_BIT_LOW: begin
          if (w_tick) begin
            if (w_rd_smp) begin
              r_shift[r_bit] <= r_sync[1];
            end
            if (r_us == w_tlow_m1) begin
              r_oe    <= 1'b0;
              r_state <= S_BIT_HIGH;
            end
            r_us <= r_us + 1'b1;
          end
        end

        S_BIT_HIGH: begin
          if (w_tick) begin
            if (w_rd_smp) begin
              r_shift[r_bit] <= r_sync[1];
            end
            if (r_us == c_tslot_m1) begin
              r_us <= '0;
              if (r_bit == 3'd7) begin
                r_state <= S_DONE;
              end else begin
                r_bit   <= r_bit + 1'b1;
                r_oe    <= 1'b1;
                r_state <= S_BIT_LOW;
              end
            end else begin
              r_us <= r_us + 1'b1;
            end
          end
        end

        S_DONE: begin
          r_rsp_vld <= 1'b1;
          r_state   <= S_IDLE;
          case (r_op)
            c_op_rst: begin
              r_rsp_pre <= r_pre_smp;
              r_rsp_err <= r_err_smp;
            end
            c_op_wr, c_op_rd: r_rsp_dat <= r_shift;
            default: ;
          endcase
        end

        default: begin
          r_oe    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_onewire_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_onewire_master_ctrl
// Brief    : Scoreboard bench for onewire_master_ctrl with a behavioural slave.
// Revision : 1.0
// ============================================================================
module tb_onewire_master_ctrl;
  localparam int c_cdr      = 10;
  localparam int c_trstl    = 480;
  localparam int c_trsth    = 480;
  localparam int c_tpds     = 70;
  localparam int c_tlow0    = 60;
  localparam int c_tlow1    = 6;
  localparam int c_trds     = 15;
  localparam int c_tslot    = 70;
  localparam int c_slot_cyc = c_tslot * c_cdr;
  localparam int c_pull_cyc = 30 * c_cdr;

  typedef struct { logic [7:0] dat; logic pre; logic err; int at; } rsp_t;
  typedef struct { int start; int width; } pulse_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  rsp_t       sb_q[$];
  pulse_t     pq[$];
  logic [7:0] m_dat = 8'h00;
  logic       m_pre = 1'b0;
  logic       m_err = 1'b0;
  int         acc_g = -100000;
  logic [7:0] sl_mask = 8'h00;
  bit         sl_pres = 1'b0;
  bit         sl_stuck = 1'b0;
  int         sl_delay = 300;
  int         sl_dur = 1500;

  onewire_master_ctrl_if bus ();

  onewire_master_ctrl #(
    .CDR(c_cdr), .TRSTL(c_trstl), .TRSTH(c_trsth), .TPDS(c_tpds),
    .TLOW0(c_tlow0), .TLOW1(c_tlow1), .TRDS(c_trds), .TSLOT(c_tslot)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected bus pulses and response derived from the protocol timing rules
  task automatic model_push(input logic [1:0] op, input logic [7:0] dat, input int acc);
    rsp_t       e;
    logic [7:0] wb;
    pulse_t     p;
    case (op)
      2'd0: begin
        m_pre = sl_pres | sl_stuck;
        m_err = sl_stuck;
        p.start = acc;
        p.width = c_trstl * c_cdr;
        pq.push_back(p);
        e.at = acc + ((c_trstl + c_trsth) * c_cdr + 2) - 1;
      end
      2'd1, 2'd2: begin
        wb    = (op == 2'd1) ? dat : 8'hFF;
        m_dat = wb & ~sl_mask;
        for (int i = 0; i < 8; i++) begin
          p.start = acc + i * c_slot_cyc;
          p.width = (wb[i] ? c_tlow1 : c_tlow0) * c_cdr;
          pq.push_back(p);
        end
        e.at = acc + (8 * c_slot_cyc + 2) - 1;
      end
      default: e.at = acc + 2 - 1;
    endcase
    e.dat = m_dat;
    e.pre = m_pre;
    e.err = m_err;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] dat, input bit do_model);
    int g = 0;
    bus.cmd_op  = op;
    bus.cmd_dat = dat;
    bus.cmd_vld = 1'b1;
    while (!bus.cmd_rdy && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("cmd_rdy_wait", bus.cmd_rdy, 1'b1);
    acc_g = cyc + 1;
    if (do_model) model_push(op, dat, acc_g);
    @(negedge clk);
    bus.cmd_vld = 1'b0;
    bus.cmd_op  = 2'($urandom);
    bus.cmd_dat = 8'($urandom);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((sb_q.size() != 0 || pq.size() != 0) && g < 12000) begin
      @(negedge clk);
      g++;
    end
    if (sb_q.size() != 0 || pq.size() != 0) begin
      check("timeout_pending", sb_q.size() + pq.size(), 0);
      sb_q.delete();
      pq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Behavioural slave: presence pulse after reset release, 30 us pulls in masked slots
  initial begin : slave
    int   pull = 0;
    int   dly = 0;
    int   idx;
    logic oe_prev = 1'b0;
    bus.owr_i = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.owr_oe && !oe_prev) begin
        idx = (cyc - acc_g) / c_slot_cyc;
        if (idx >= 0 && idx < 8 && sl_mask[idx]) pull = c_pull_cyc;
      end
      if (!bus.owr_oe && oe_prev && sl_pres) dly = sl_delay;
      if (dly > 0) begin
        dly--;
        if (dly == 0) pull = sl_dur;
      end
      bus.owr_i = !(bus.owr_oe || pull > 0 || sl_stuck);
      if (pull > 0) pull--;
      oe_prev = bus.owr_oe;
    end
  end

  initial begin : monitor
    rsp_t   e;
    pulse_t p;
    int     pstart = 0;
    int     pw = 0;
    logic   oe_q = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rsp_vld === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", bus.rsp_vld, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_cycle", cyc, e.at);
          check("rsp_dat", bus.rsp_dat, e.dat);
          check("rsp_pre", bus.rsp_pre, e.pre);
          check("rsp_err", bus.rsp_err, e.err);
        end
      end
      if (bus.owr_oe && !oe_q) begin
        pstart = cyc;
        pw     = 0;
      end
      if (bus.owr_oe) pw++;
      if (!bus.owr_oe && oe_q) begin
        if (pq.size() == 0) begin
          check("oe_unexpected", pw, 0);
        end else begin
          p = pq.pop_front();
          check("oe_start", pstart, p.start);
          check("oe_width", pw, p.width);
        end
      end
      oe_q = bus.owr_oe;
    end
  end

  initial begin : stim
    logic [7:0] dat;
    logic [1:0] op;
    pulse_t     p;
    bus.cmd_vld = 1'b0;
    bus.cmd_op  = 2'b00;
    bus.cmd_dat = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_oe", bus.owr_oe, 1'b0);
    check("rst_rsp_vld", bus.rsp_vld, 1'b0);
    check("rst_rsp_dat", bus.rsp_dat, 8'h00);
    check("rst_rsp_pre", bus.rsp_pre, 1'b0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_cmd_rdy", bus.cmd_rdy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_rdy", bus.cmd_rdy, 1'b1);

    // reset op with slave presence, then with pullup only
    sl_pres  = 1'b1;
    sl_delay = $urandom_range(200, 500);
    sl_dur   = $urandom_range(1000, 2000);
    issue(2'd0, 8'h00, 1'b1);
    wait_idle();
    sl_pres = 1'b0;
    issue(2'd0, 8'h00, 1'b1);
    wait_idle();

    issue(2'd1, 8'h55, 1'b1);
    wait_idle();
    sl_mask = 8'h0A;
    issue(2'd2, 8'h00, 1'b1);
    wait_idle();
    sl_mask = 8'h00;

    // abort a write during the slot-3 low phase
    dat = 8'($urandom);
    issue(2'd1, dat, 1'b0);
    for (int i = 0; i < 3; i++) begin
      p.start = acc_g + i * c_slot_cyc;
      p.width = (dat[i] ? c_tlow1 : c_tlow0) * c_cdr;
      pq.push_back(p);
    end
    p.start = acc_g + 3 * c_slot_cyc;
    p.width = 21;
    pq.push_back(p);
    while (cyc < acc_g + 3 * c_slot_cyc + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_oe", bus.owr_oe, 1'b0);
    check("abort_cmd_rdy", bus.cmd_rdy, 1'b0);
    m_dat = 8'h00;
    m_pre = 1'b0;
    m_err = 1'b0;
    check("abort_rsp_dat", bus.rsp_dat, m_dat);
    check("abort_rsp_pre", bus.rsp_pre, m_pre);
    check("abort_rsp_err", bus.rsp_err, m_err);
    rst = 1'b0;
    @(negedge clk);
    check("abort_rdy_after", bus.cmd_rdy, 1'b1);
    repeat (20) @(negedge clk);

    sl_pres  = 1'b1;
    sl_delay = $urandom_range(200, 500);
    sl_dur   = $urandom_range(1000, 2000);
    issue(2'd0, 8'h00, 1'b1);
    wait_idle();
    sl_pres = 1'b0;

    // line stuck low for the whole reset op
    sl_stuck = 1'b1;
    issue(2'd0, 8'h00, 1'b1);
    wait_idle();
    sl_stuck = 1'b0;
    repeat (5) @(negedge clk);

    issue(2'd3, 8'($urandom), 1'b1);
    wait_idle();

    for (int k = 0; k < 4; k++) begin
      op      = 2'($urandom_range(1, 3));
      dat     = 8'($urandom);
      sl_mask = (op == 2'd3) ? 8'h00 : 8'($urandom);
      issue(op, dat, 1'b1);
      if (op != 2'd3) begin
        repeat (100) @(negedge clk);
        check("busy_cmd_rdy", bus.cmd_rdy, 1'b0);
        bus.cmd_op  = 2'd0;
        bus.cmd_vld = 1'b1;
        repeat (5) @(negedge clk);
        bus.cmd_vld = 1'b0;
      end
      wait_idle();
      sl_mask = 8'h00;
    end

    repeat (20) @(negedge clk);
    check("end_sb_empty", sb_q.size(), 0);
    check("end_pulse_empty", pq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
